mmc_card_command_responder: RTL

Card-side CMD-line endpoint for the MMC emulation path. It receives byte-assembled 48-bit commands from the CMD-line bit shifter, checks framing and CRC7, and presents index and argument to the card application logic. After a programmable N_CR gap it serialises the application's response bytes back to the shifter, appending CRC7 on request. It is the responder-side counterpart of the host command I/O block.

---
 rtl/mmc_card_command_responder_if.sv | 36 +++
 rtl/mmc_card_command_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_card_command_responder_if.sv
// Bus between the CMD-line shifter/card application and the card-side command responder.
// The responder uses the slave view; the shifter/application side uses the master view.
interface mmc_card_command_responder_if;
    logic        reset_command_state;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        command_valid;
    logic        command_error;
    logic [5:0]  command_index;
    logic [31:0] command_argument;
    logic        response_request;
    logic [2:0]  response_length;
    logic [47:0] response_data;
    logic        response_append_crc;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;
    logic        cmd_drive_enable;
    logic        busy;

    modport slave (
        input  reset_command_state, rx_byte, rx_byte_valid,
        input  response_request, response_length, response_data, response_append_crc,
        input  tx_byte_ready,
        output command_valid, command_error, command_index, command_argument,
        output tx_byte, tx_byte_valid, cmd_drive_enable, busy
    );

    modport master (
        output reset_command_state, rx_byte, rx_byte_valid,
        output response_request, response_length, response_data, response_append_crc,
        output tx_byte_ready,
        input  command_valid, command_error, command_index, command_argument,
        input  tx_byte, tx_byte_valid, cmd_drive_enable, busy
    );
endinterface

// File: rtl/mmc_card_command_responder.sv
// Card-side CMD-line endpoint: receives 48-bit commands with CRC7 check, then
// sends N_CR filler bytes and the application's response with optional CRC7.
module mmc_card_command_responder #(
    parameter int NCR_BYTES = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    mmc_card_command_responder_if.slave         bus
);

    typedef enum logic [1:0] {RECV_CMD, WAIT_APP, SEND_GAP, SEND_RESP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(NCR_BYTES - 1);

    // x^7 + x^3 + 1, MSB first, one whole byte per call
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [6:0]  crc_reg, crc_next;
    // Start/transmission bits of byte 0 are validated on entry, so only 38 bits are kept.
    logic [37:0] cmd_buf_reg, cmd_buf_next;
    logic        command_valid_reg, command_valid_next;
    logic        command_error_reg, command_error_next;
    logic [5:0]  command_index_reg, command_index_next;
    logic [31:0] command_argument_reg, command_argument_next;
    logic [2:0]  resp_len_reg, resp_len_next;
    logic [47:0] resp_data_reg, resp_data_next;
    logic        resp_crc_en_reg, resp_crc_en_next;
    logic        crc_sent_reg, crc_sent_next;
    logic [2:0]  resp_idx_reg, resp_idx_next;
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        drive_reg, drive_next;

    logic [7:0]  resp_bytes [8];
    logic        xfer;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_resp_bytes
            assign resp_bytes[gi] = resp_data_reg[47 - 8*gi -: 8];
        end
        for (gi = 6; gi < 8; gi++) begin : g_resp_pad
            assign resp_bytes[gi] = 8'hFF;
        end
    endgenerate

    assign xfer = tx_valid_reg && bus.tx_byte_ready;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_reg            <= RECV_CMD;
            byte_cnt_reg         <= 3'd0;
            crc_reg              <= 7'd0;
            cmd_buf_reg          <= 38'd0;
            command_valid_reg    <= 1'b0;
            command_error_reg    <= 1'b0;
            command_index_reg    <= 6'd0;
            command_argument_reg <= 32'd0;
            resp_len_reg         <= 3'd0;
            resp_data_reg        <= 48'd0;
            resp_crc_en_reg      <= 1'b0;
            crc_sent_reg         <= 1'b0;
            resp_idx_reg         <= 3'd0;
            gap_cnt_reg          <= 4'd0;
            tx_byte_reg          <= 8'hFF;
            tx_valid_reg         <= 1'b0;
            drive_reg            <= 1'b0;
        end else begin
            state_reg            <= state_next;
            byte_cnt_reg         <= byte_cnt_next;
            crc_reg              <= crc_next;
            cmd_buf_reg          <= cmd_buf_next;
            command_valid_reg    <= command_valid_next;
            command_error_reg    <= command_error_next;
            command_index_reg    <= command_index_next;
            command_argument_reg <= command_argument_next;
            resp_len_reg         <= resp_len_next;
            resp_data_reg        <= resp_data_next;
            resp_crc_en_reg      <= resp_crc_en_next;
            crc_sent_reg         <= crc_sent_next;
            resp_idx_reg         <= resp_idx_next;
            gap_cnt_reg          <= gap_cnt_next;
            tx_byte_reg          <= tx_byte_next;
            tx_valid_reg         <= tx_valid_next;
            drive_reg            <= drive_next;
        end
    end

    always_comb begin
        state_next            = state_reg;
        byte_cnt_next         = byte_cnt_reg;
        crc_next              = crc_reg;
        cmd_buf_next          = cmd_buf_reg;
        command_valid_next    = 1'b0;
        command_error_next    = 1'b0;
        command_index_next    = command_index_reg;
        command_argument_next = command_argument_reg;
        resp_len_next         = resp_len_reg;
        resp_data_next        = resp_data_reg;
        resp_crc_en_next      = resp_crc_en_reg;
        crc_sent_next         = crc_sent_reg;
        resp_idx_next         = resp_idx_reg;
        gap_cnt_next          = gap_cnt_reg;
        tx_byte_next          = tx_byte_reg;
        tx_valid_next         = tx_valid_reg;
        drive_next            = drive_reg;

        if (bus.reset_command_state) begin
            // Abort: everything but the last good command returns to idle
            state_next    = RECV_CMD;
            byte_cnt_next = 3'd0;
            crc_next      = 7'd0;
            crc_sent_next = 1'b0;
            resp_idx_next = 3'd0;
            gap_cnt_next  = 4'd0;
            tx_byte_next  = 8'hFF;
            tx_valid_next = 1'b0;
            drive_next    = 1'b0;
        end else begin
            case (state_reg)
                RECV_CMD: begin
                    if (bus.rx_byte_valid && !(byte_cnt_reg == 3'd0 && bus.rx_byte[7:6] != 2'b01)) begin
                        if (byte_cnt_reg != 3'd5) begin
                            cmd_buf_next  = {cmd_buf_reg[29:0], bus.rx_byte};
                            crc_next      = crc7_byte(crc_reg, bus.rx_byte);
                            byte_cnt_next = byte_cnt_reg + 3'd1;
                        end else begin
                            byte_cnt_next = 3'd0;
                            crc_next      = 7'd0;
                            if (bus.rx_byte[7:1] == crc_reg && bus.rx_byte[0]) begin
                                command_index_next    = cmd_buf_reg[37:32];
                                command_argument_next = cmd_buf_reg[31:0];
                                command_valid_next    = 1'b1;
                                state_next            = WAIT_APP;
                            end else begin
                                command_error_next = 1'b1;
                            end
                        end
                    end
                end
                WAIT_APP: begin
                    // A request coincident with the command_valid pulse is too early to honour
                    if (bus.response_request && !command_valid_reg) begin
                        resp_len_next    = (bus.response_length == 3'd7) ? 3'd6 : bus.response_length;
                        resp_data_next   = bus.response_data;
                        resp_crc_en_next = bus.response_append_crc;
                        if (bus.response_length == 3'd0 && !bus.response_append_crc) begin
                            state_next = RECV_CMD;
                        end else begin
                            state_next    = SEND_GAP;
                            gap_cnt_next  = 4'd0;
                            tx_byte_next  = 8'hFF;
                            tx_valid_next = 1'b1;
                            drive_next    = 1'b1;
                        end
                    end
                end
                SEND_GAP: begin
                    if (xfer) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            state_next   = SEND_RESP;
                            gap_cnt_next = 4'd0;
                            if (resp_len_reg != 3'd0) begin
                                tx_byte_next  = resp_bytes[0];
                                crc_next      = crc7_byte(7'd0, resp_bytes[0]);
                                resp_idx_next = 3'd1;
                                crc_sent_next = 1'b0;
                            end else begin
                                tx_byte_next  = 8'h01;
                                crc_next      = 7'd0;
                                resp_idx_next = 3'd0;
                                crc_sent_next = 1'b1;
                            end
                        end else begin
                            gap_cnt_next = gap_cnt_reg + 4'd1;
                        end
                    end
                end
                SEND_RESP: begin
                    if (xfer) begin
                        if (resp_idx_reg < resp_len_reg) begin
                            tx_byte_next  = resp_bytes[resp_idx_reg];
                            crc_next      = crc7_byte(crc_reg, resp_bytes[resp_idx_reg]);
                            resp_idx_next = resp_idx_reg + 3'd1;
                        end else if (resp_crc_en_reg && !crc_sent_reg) begin
                            tx_byte_next  = {crc_reg, 1'b1};
                            crc_sent_next = 1'b1;
                        end else begin
                            state_next    = RECV_CMD;
                            tx_byte_next  = 8'hFF;
                            tx_valid_next = 1'b0;
                            drive_next    = 1'b0;
                            crc_next      = 7'd0;
                            resp_idx_next = 3'd0;
                            crc_sent_next = 1'b0;
                        end
                    end
                end
                default: state_next = RECV_CMD;
            endcase
        end
    end

    assign bus.command_valid    = command_valid_reg;
    assign bus.command_error    = command_error_reg;
    assign bus.command_index    = command_index_reg;
    assign bus.command_argument = command_argument_reg;
    assign bus.tx_byte          = tx_byte_reg;
    assign bus.tx_byte_valid    = tx_valid_reg;
    assign bus.cmd_drive_enable = drive_reg;
    assign bus.busy             = (state_reg != RECV_CMD);

endmodule
